// File: rtl/serial_frame_tx.sv
// serial_frame_tx: framed LSB-first serializer (start bit, N data bits, optional parity, stop bit).
// Define SERIAL_TX_PARITY_EN to insert an even-parity bit between the data and stop bits.
module serial_frame_tx #(
   parameter int N         = 8,
   parameter int BIT_TICKS = 1
) (
   input  logic         clk,
   input  logic         clr,
   input  logic [N-1:0] in_data,
   input  logic         in_valid,
   output logic         in_ready,
   output logic         sout,
   output logic         busy,
   output logic         done
);

   localparam int TW = (BIT_TICKS > 1) ? $clog2(BIT_TICKS) : 1;
   localparam int BW = (N > 1) ? $clog2(N) : 1;
   localparam logic [TW-1:0] TICK_LAST = TW'(BIT_TICKS - 1);
   localparam logic [BW-1:0] BIT_LAST  = BW'(N - 1);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
`ifdef SERIAL_TX_PARITY_EN
      PARITY = 3'd3,
`endif
      STOP   = 3'd4
   } state_t;

   state_t         state_q, state_d;
   logic [TW-1:0]  tick_q, tick_d;
   logic [BW-1:0]  bit_q, bit_d;
   logic [N-1:0]   shift_q, shift_d;
   logic           sout_q, sout_d;
   logic           busy_q, busy_d;
   logic           done_q, done_d;
   logic           tick_end;
`ifdef SERIAL_TX_PARITY_EN
   logic           par_q, par_d;
`endif

   // Handshake: a word transfers on a rising edge where in_valid and in_ready are both
   // high and clr is low; in_ready depends only on the state, never on in_valid.
   assign in_ready = (state_q == IDLE);
   assign sout     = sout_q;
   assign busy     = busy_q;
   assign done     = done_q;

   assign tick_end = (tick_q == TICK_LAST);

   always_comb begin
      state_d = state_q;
      tick_d  = tick_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      done_d  = 1'b0;
`ifdef SERIAL_TX_PARITY_EN
      par_d   = par_q;
`endif

      case (state_q)
         IDLE: begin
            tick_d = '0;
            bit_d  = '0;
            if (in_valid) begin
               state_d = START;
               shift_d = in_data;
`ifdef SERIAL_TX_PARITY_EN
               par_d   = ^in_data;
`endif
            end
         end
         START: begin
            if (tick_end) begin
               state_d = DATA;
               bit_d   = '0;
            end
         end
         DATA: begin
            if (tick_end) begin
               shift_d = shift_q >> 1;
               if (bit_q == BIT_LAST) begin
                  bit_d = '0;
`ifdef SERIAL_TX_PARITY_EN
                  state_d = PARITY;
`else
                  state_d = STOP;
`endif
               end else begin
                  bit_d = bit_q + BW'(1);
               end
            end
         end
`ifdef SERIAL_TX_PARITY_EN
         PARITY: begin
            if (tick_end) state_d = STOP;
         end
`endif
         STOP: begin
            if (tick_end) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      // The bit-period counter runs in every state except IDLE and restarts at each bit boundary.
      if (state_q != IDLE) begin
         tick_d = tick_end ? '0 : tick_q + TW'(1);
      end
   end

   // Outputs are registered from the next-state view so sout lines up with the state it reflects.
   always_comb begin
      sout_d = 1'b1;
      case (state_d)
         IDLE:   sout_d = 1'b1;
         START:  sout_d = 1'b0;
         DATA:   sout_d = shift_d[0];
`ifdef SERIAL_TX_PARITY_EN
         PARITY: sout_d = par_d;
`endif
         STOP:   sout_d = 1'b1;
         default: sout_d = 1'b1;
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         state_q <= IDLE;
         tick_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         sout_q  <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
         par_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         tick_q  <= tick_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         sout_q  <= sout_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
`ifdef SERIAL_TX_PARITY_EN
         par_q   <= par_d;
`endif
      end
   end

endmodule

// File: tb/tb_serial_frame_tx.sv
// Bench for serial_frame_tx: two instances (BIT_TICKS=1 and 4) checked every cycle against a
// frame-level model, plus directed frames with hand-computed bit patterns.
module tb_serial_frame_tx;
   localparam int N = 8;
`ifdef SERIAL_TX_PARITY_EN
   localparam int P = 1;
   localparam logic [N+2:0] A5_EXP = 11'h54A;
   localparam logic [N+2:0] H07_EXP = 11'h60E;
   localparam logic [N+2:0] H55_EXP = 11'h4AA;
`else
   localparam int P = 0;
   localparam logic [N+1:0] A5_EXP = 10'h34A;
   localparam logic [N+1:0] H07_EXP = 10'h20E;
   localparam logic [N+1:0] H55_EXP = 10'h2AA;
`endif
   localparam int FB = N + 2 + P;
   // Per-cycle expectation packed as {sout, busy, done, in_ready}.
   localparam logic [3:0] IDLE_EXP = 4'b1001;

   logic         clk = 1'b0;
   logic         clr = 1'b1;
   logic         in_valid = 1'b0;
   logic [N-1:0] in_data = '0;
   logic         d1_ready, d1_sout, d1_busy, d1_done;
   logic         d4_ready, d4_sout, d4_busy, d4_done;

   int total = 0;
   int bad = 0;
   logic [3:0] exp1_q[$];
   logic [3:0] exp4_q[$];
   logic armed = 1'b0;
   logic [FB-1:0] sr = '0;

   serial_frame_tx #(.N(N), .BIT_TICKS(1)) dut1 (
      .clk(clk), .clr(clr), .in_data(in_data), .in_valid(in_valid),
      .in_ready(d1_ready), .sout(d1_sout), .busy(d1_busy), .done(d1_done)
   );

   serial_frame_tx #(.N(N), .BIT_TICKS(4)) dut4 (
      .clk(clk), .clr(clr), .in_data(in_data), .in_valid(in_valid),
      .in_ready(d4_ready), .sout(d4_sout), .busy(d4_busy), .done(d4_done)
   );

   // clock / reset
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Cycle k of a frame, counted from the first start-bit cycle; the cycle after the frame is the done cycle.
   function automatic logic [3:0] frame_entry(input logic [N-1:0] d, input int bt, input int k);
      int pos;
      logic b;
      if (k >= FB * bt) return 4'b1011;
      pos = k / bt;
      if (pos == 0) b = 1'b0;
      else if (pos <= N) b = d[pos-1];
      else if (P == 1 && pos == N + 1) b = ^d;
      else b = 1'b1;
      return {b, 3'b100};
   endfunction

   // model: advance one cycle per edge, start a frame on an accepted word
   always @(posedge clk) begin
      logic [3:0] cur1, cur4;
      if (exp1_q.size() > 0) cur1 = exp1_q.pop_front(); else cur1 = IDLE_EXP;
      if (exp4_q.size() > 0) cur4 = exp4_q.pop_front(); else cur4 = IDLE_EXP;
      if (clr) begin
         exp1_q.delete();
         exp4_q.delete();
      end else if (in_valid) begin
         if (cur1[0]) for (int k = 0; k <= FB; k++) exp1_q.push_back(frame_entry(in_data, 1, k));
         if (cur4[0]) for (int k = 0; k <= FB * 4; k++) exp4_q.push_back(frame_entry(in_data, 4, k));
      end
      armed <= 1'b1;
   end

   // downstream shift register fed by the BIT_TICKS=1 line
   always @(posedge clk) sr <= {d1_sout, sr[FB-1:1]};

   // scoreboard compare
   always @(negedge clk) begin
      if (armed) begin
         check("d1_cycle", {d1_sout, d1_busy, d1_done, d1_ready},
               (exp1_q.size() > 0) ? exp1_q[0] : IDLE_EXP);
         check("d4_cycle", {d4_sout, d4_busy, d4_done, d4_ready},
               (exp4_q.size() > 0) ? exp4_q[0] : IDLE_EXP);
      end
   end

   // driver tasks
   task automatic wait_ready(input string name);
      int n = 0;
      @(negedge clk);
      while (!(d1_ready && d4_ready) && n < 200) begin
         @(negedge clk);
         n++;
      end
      check(name, (n < 200), 1'b1);
   endtask

   task automatic send_capture(input logic [N-1:0] d, output logic [FB-1:0] vec,
                               output logic done_bit, output logic [FB-1:0] sr_snap);
      in_data = d;
      in_valid = 1'b1;
      @(posedge clk);
      #2;
      in_valid = 1'b0;
      for (int k = 0; k < FB; k++) begin
         @(negedge clk);
         vec[k] = d1_sout;
      end
      @(negedge clk);
      done_bit = d1_done;
      sr_snap = sr;
   endtask

   initial begin
      logic [FB-1:0] vec, srs;
      logic dn;
      logic [4*FB-1:0] s4v;
      int cnt;

      // reset with a word offered during clr
      in_valid = 1'b1;
      in_data = 8'h99;
      repeat (3) @(posedge clk);
      #2;
      clr = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      check("reset_outputs", {d1_sout, d1_busy, d1_done, d1_ready}, 4'b1001);
      repeat (3) @(negedge clk);
      check("reset_word_dropped", {d1_busy, d4_busy}, 2'b00);

      // single frame A5
      wait_ready("ready_a5");
      send_capture(8'hA5, vec, dn, srs);
      check("a5_bits", vec, A5_EXP);
      check("a5_done", dn, 1'b1);
      check("a5_shiftreg", srs, A5_EXP);

      // bit stretching on the BIT_TICKS=4 instance
      wait_ready("ready_01");
      in_data = 8'h01;
      in_valid = 1'b1;
      @(posedge clk);
      #2;
      in_valid = 1'b0;
      cnt = 0;
      for (int k = 0; k < 4 * FB; k++) begin
         @(negedge clk);
         s4v[k] = d4_sout;
         cnt += int'(d4_busy);
      end
      @(negedge clk);
      check("bt4_start", s4v[3:0], 4'h0);
      check("bt4_bit0", s4v[7:4], 4'hF);
      check("bt4_zeros", s4v[35:8], 28'h0);
      check("bt4_tail", s4v[4*FB-1:36], {(4*FB-36){1'b1}});
      check("bt4_busy_len", cnt, 4 * FB);
      check("bt4_done", d4_done, 1'b1);

      // parity-sensitive frame
      wait_ready("ready_07");
      send_capture(8'h07, vec, dn, srs);
      check("h07_bits", vec, H07_EXP);
      check("h07_done", dn, 1'b1);

      // back-to-back with in_valid held high
      wait_ready("ready_b2b");
      in_data = 8'h3C;
      in_valid = 1'b1;
      @(posedge clk);
      #2;
      in_data = 8'hFF;
      cnt = 0;
      for (int k = 0; k < FB; k++) begin
         @(negedge clk);
         cnt += int'(d1_ready);
      end
      check("b2b_ready_low", cnt, 0);
      @(negedge clk);
      check("b2b_gap", {d1_sout, d1_ready, d1_done}, 3'b111);
      @(posedge clk);
      #2;
      in_valid = 1'b0;
      @(negedge clk);
      check("b2b_next_start", {d1_sout, d1_busy, d1_ready}, 3'b010);

      // mid-frame reset during data bit 3 of F0
      wait_ready("ready_f0");
      in_data = 8'hF0;
      in_valid = 1'b1;
      @(posedge clk);
      #2;
      in_valid = 1'b0;
      repeat (4) @(posedge clk);
      #2;
      clr = 1'b1;
      @(negedge clk);
      check("f0_bit3", {d1_sout, d1_busy}, 2'b01);
      @(posedge clk);
      #2;
      clr = 1'b0;
      @(negedge clk);
      check("abort_outputs", {d1_sout, d1_busy, d1_done}, 3'b100);
      cnt = 0;
      repeat (FB + 2) begin
         @(negedge clk);
         cnt += int'(d1_done);
      end
      check("abort_no_done", cnt, 0);
      wait_ready("ready_55");
      send_capture(8'h55, vec, dn, srs);
      check("h55_bits", vec, H55_EXP);
      check("h55_done", dn, 1'b1);

      // randomized traffic with occasional resets
      for (int i = 0; i < 400; i++) begin
         in_valid = 1'($urandom_range(0, 1));
         in_data = N'($urandom);
         clr = ($urandom_range(0, 59) == 0);
         @(posedge clk);
         #2;
      end
      clr = 1'b0;
      in_valid = 1'b0;
      wait_ready("ready_drain");
      repeat (5) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
